// File: rtl/vend_client.sv
// vend_client: drives a vending machine on behalf of a single purchase request.
// It validates the request, inserts the credit as a greedy sequence of coins,
// presses the drink button, then waits for the beverage and for any change.
// The result (status and change) is reported with a one-cycle done pulse.

module vend_client #(
  parameter int BEV_TIMEOUT = 16,
  parameter int CHG_WINDOW  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_drink,
  input  logic [15:0] req_amount,
  output logic [15:0] coin_in,
  output logic [1:0]  button_in,
  input  logic [1:0]  beverage_out,
  input  logic [15:0] change_out,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] change_total
);

  typedef enum logic [2:0] {
    IDLE,
    INSERT,
    PRESS,
    WAIT_BEV,
    WAIT_CHG,
    DONE
  } state_t;

  localparam logic [1:0] DRINK_WATER = 2'b01;
  localparam logic [1:0] DRINK_SODA  = 2'b11;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0] STATUS_REJECT  = 2'b10;

  localparam logic [15:0] PRICE_WATER = 16'd30;
  localparam logic [15:0] PRICE_SODA  = 16'd50;
  localparam logic [15:0] MAX_AMOUNT  = 16'd1000;

  // The timer is only 5 bits wide, so the limits are brought to the same width.
  localparam logic [4:0] BEV_LIMIT = 5'(BEV_TIMEOUT);
  localparam logic [4:0] CHG_LIMIT = 5'(CHG_WINDOW);

  state_t      state_q, state_d;
  logic [1:0]  drink_q, drink_d;
  logic [15:0] remaining_q, remaining_d;
  logic [4:0]  timer_q, timer_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] change_q, change_d;

  logic        drinkOk;
  logic [15:0] reqPrice;
  logic        reqOk;
  logic [15:0] insertCoin;
  logic [4:0]  timerInc;

  // Largest coin denomination that still fits in the remaining credit.
  function automatic logic [15:0] greedyCoin(input logic [15:0] rem);
    logic [15:0] coin;
    coin = 16'd0;
    if (rem >= 16'd200) begin
      coin = 16'd200;
    end else if (rem >= 16'd100) begin
      coin = 16'd100;
    end else if (rem >= 16'd50) begin
      coin = 16'd50;
    end else if (rem >= 16'd20) begin
      coin = 16'd20;
    end else if (rem >= 16'd10) begin
      coin = 16'd10;
    end
    return coin;
  endfunction

  // Request validation: known drink, nonzero whole multiple of 10, within the
  // credit ceiling and at least the drink price. These checks also guarantee
  // the greedy coin loop always ends exactly at zero.
  always_comb begin
    drinkOk  = (req_drink == DRINK_WATER) || (req_drink == DRINK_SODA);
    reqPrice = (req_drink == DRINK_SODA) ? PRICE_SODA : PRICE_WATER;
    reqOk    = drinkOk &&
               (req_amount != 16'd0) &&
               ((req_amount % 16'd10) == 16'd0) &&
               (req_amount <= MAX_AMOUNT) &&
               (req_amount >= reqPrice);
  end

  // Coin for the current INSERT cycle and the saturating timer increment.
  always_comb begin
    insertCoin = greedyCoin(remaining_q);
    timerInc   = (timer_q == 5'h1F) ? timer_q : (timer_q + 5'd1);
  end

  // Next-state and output decode for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    drink_d     = drink_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    status_d    = status_q;
    change_d    = change_q;
    req_ready   = 1'b0;
    coin_in     = 16'd0;
    button_in   = 2'b00;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          drink_d  = req_drink;
          timer_d  = 5'd0;
          change_d = 16'd0;
          if (reqOk) begin
            remaining_d = req_amount;
            status_d    = STATUS_OK;
            state_d     = INSERT;
          end else begin
            remaining_d = 16'd0;
            status_d    = STATUS_REJECT;
            state_d     = DONE;
          end
        end
      end

      INSERT: begin
        coin_in     = insertCoin;
        remaining_d = remaining_q - insertCoin;
        if (remaining_q == insertCoin) begin
          state_d = PRESS;
        end
      end

      PRESS: begin
        button_in = drink_q;
        timer_d   = 5'd0;
        state_d   = WAIT_BEV;
      end

      WAIT_BEV: begin
        if (beverage_out == drink_q) begin
          timer_d = 5'd0;
          state_d = WAIT_CHG;
        end else if (timerInc >= BEV_LIMIT) begin
          status_d = STATUS_TIMEOUT;
          change_d = 16'd0;
          state_d  = DONE;
        end else begin
          timer_d = timerInc;
        end
      end

      WAIT_CHG: begin
        if (change_out != 16'd0) begin
          change_d = change_out;
          status_d = STATUS_OK;
          state_d  = DONE;
        end else if (timerInc >= CHG_LIMIT) begin
          change_d = 16'd0;
          status_d = STATUS_OK;
          state_d  = DONE;
        end else begin
          timer_d = timerInc;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered state; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drink_q     <= 2'b00;
      remaining_q <= 16'd0;
      timer_q     <= 5'd0;
      status_q    <= STATUS_OK;
      change_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      drink_q     <= drink_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      status_q    <= status_d;
      change_q    <= change_d;
    end
  end

  assign status       = status_q;
  assign change_total = change_q;

endmodule

// File: doc/vend_client.md
VEND_CLIENT -- requirements
Module: vend_client

Interface
REQ-001 Parameter BEV_TIMEOUT, default 16: maximum cycles in WAIT_BEV before giving up.
REQ-002 Parameter CHG_WINDOW, default 6: cycles in WAIT_CHG spent watching for change.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  purchase request present.
- req_ready  out  1  block idle and able to accept a request.
- req_drink  in  2  01 water (price 30), 11 soda (price 50); other codes invalid.
- req_amount  in  16  total credit to insert.
- coin_in  out  16  coin driven to the vending machine; 0 means no coin.
- button_in  out  2  drink button driven to the vending machine.
- beverage_out  in  2  beverage strobe from the vending machine.
- change_out  in  16  change value from the vending machine.
- done  out  1  one-cycle completion pulse.
- status  out  2  00 OK, 01 TIMEOUT, 10 REJECTED; valid while done=1 and held until the next accept.
- change_total  out  16  change captured for the last transaction.

Function
REQ-004 States: IDLE, INSERT, PRESS, WAIT_BEV, WAIT_CHG, DONE.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-006 On accept, drink and amount SHALL be latched; later changes to the req_* inputs have no effect.
REQ-007 A request SHALL be rejected if any of the following hold: drink is not 01 or 11; amount=0; amount is not a multiple of 10; amount>1000; amount<price.
REQ-008 On rejection, the FSM SHALL go IDLE->DONE with status=10, change_total=0, and no coin or button activity.
REQ-009 A valid request SHALL go IDLE->INSERT with remaining=amount.
REQ-010 In INSERT, each cycle SHALL drive coin_in with the largest of 200/100/50/20/10 that is <= remaining, and subtract that coin from remaining at the edge.
REQ-011 INSERT SHALL hold for exactly the number of coins in the greedy decomposition, one coin per cycle with no gaps, then move to PRESS.
REQ-012 PRESS SHALL last exactly one cycle with button_in=latched drink and coin_in=0, then move to WAIT_BEV with the timer cleared.
REQ-013 Outside INSERT, coin_in SHALL be 0; outside PRESS, button_in SHALL be 00.
REQ-014 In WAIT_BEV, when beverage_out equals the latched drink, the FSM SHALL move to WAIT_CHG with the timer cleared.
REQ-015 In WAIT_BEV, if BEV_TIMEOUT cycles elapse without a match, the FSM SHALL move to DONE with status=01 and change_total=0.
REQ-016 A beverage_out value that is nonzero but does not match the drink SHALL be ignored and SHALL NOT reset the timer.
REQ-017 In WAIT_CHG, the first cycle with change_out!=0 SHALL capture change_out into change_total and move to DONE with status=00.
REQ-018 If CHG_WINDOW cycles elapse in WAIT_CHG without change, the FSM SHALL move to DONE with status=00 and change_total=0.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 The timer SHALL be 5 bits and saturate, never wrapping; timeout compares use ">= parameter".
REQ-021 remaining SHALL be 16 bits unsigned; the greedy step SHALL never underflow given the REQ-007 checks.
REQ-022 req_valid held high during DONE SHALL be accepted in the IDLE cycle that follows, never in DONE.

Reset
REQ-023 When rst=1, asynchronously: state=IDLE, coin_in=0, button_in=00, done=0, status=00, change_total=0, remaining=0, timer=0, req_ready=1 after reset is released.
REQ-024 Reset asserted mid-transaction SHALL abort it without a done pulse; coin_in and button_in SHALL drop to 0 immediately.

Verification
REQ-025 Water, amount=50: coins 50 in 1 cycle -> button 01 for 1 cycle -> beverage_out=01 -> change_out=20 -> done, status=00, change_total=20.
REQ-026 Soda, amount=380: coins 200,100,50,20,10 on consecutive cycles -> button 11 -> beverage 11 -> no change within 6 cycles -> status=00, change_total=0.
REQ-027 Soda, amount=40 (below price), plus amount=35 and drink=10 -> each gives done with status=10 and no coin or button activity.
REQ-028 Water, amount=30, beverage_out held at 00 -> done exactly 16 cycles after entering WAIT_BEV, with status=01.
REQ-029 rst pulsed during INSERT of amount=300 -> coin_in=0 at once, no done, req_ready=1 after release; a new request is accepted normally.
REQ-030 req_valid held high continuously -> back-to-back transactions, each separated by DONE then one IDLE cycle.
